page_walker: RTL
================

// Module: page_walker
// PURPOSE
//   Sv32 hardware page-table walker: the responder side of the PageWalk_Req/PageWalk_Res interface used by the ITLB/DTLB miss paths.
//   Arbitrates among NUM_RQ requestors, performs up to two PTE reads through a single-outstanding memory read port, and returns a translation or page fault.
//   Requestors hold their request while pw_busy=1 and stall while pw_busy=1 && pw_rqID==own ID.
//   No A/D bit updates; PTE with A=0 (or D=0 on write-permission use) is reported as-is / faulted per rules below.
// PARAMETERS
//   NUM_RQ      2   number of requestors; index = rqID (0 = ifetch, 1 = load/store)
//   RQID_W      1   width of rqID, = max(1,$clog2(NUM_RQ))
// PORTS
//   clk          in   1            clock
//   rst          in   1            synchronous, active-high reset
//   IN_reqValid  in   NUM_RQ       per-requestor walk request
//   IN_reqAddr   in   NUM_RQ*32    virtual address per requestor (only [31:12] used)
//   IN_reqRoot   in   NUM_RQ*22    satp root PPN per requestor
//   OUT_busy     out  1            walker owns a request (PageWalk_Res.busy)
//   OUT_rqID     out  RQID_W       owner of current/last walk
//   OUT_valid    out  1            result strobe, one cycle
//   OUT_vpn      out  20           VPN of the completed walk
//   OUT_ppn      out  20           leaf PPN (PTE[29:10])
//   OUT_isSuper  out  1            leaf found at level 1 (4 MiB page)
//   OUT_rwx      out  3            {R,W,X} = {PTE[1],PTE[2],PTE[3]}
//   OUT_user     out  1            PTE.U
//   OUT_pageFault out 1            walk ended in fault; other result fields 0
//   OUT_memRe    out  1            PTE read request
//   OUT_memAddr  out  32           PTE physical address, word aligned
//   IN_memReady  in   1            memory accepts read this cycle
//   IN_memValid  in   1            read data valid (exactly one per accepted read)
//   IN_memData   in   32           PTE
// BEHAVIOUR
//   Reset: state=IDLE; OUT_busy=0, OUT_valid=0, OUT_memRe=0, OUT_rqID=0, all result fields 0. Memory side is reset by the same rst; no response outstanding after reset.
//   States: IDLE -> L1_REQ -> L1_WAIT -> {L0_REQ -> L0_WAIT ->} DONE -> IDLE.
//   IDLE: if any IN_reqValid, accept lowest index i; latch vpn=IN_reqAddr[i][31:12], root; OUT_rqID<=i; next L1_REQ; OUT_busy=1 from next cycle.
//   Accept only when OUT_busy=0; requests seen while busy are ignored (requestor holds them).
//   L1_REQ: OUT_memRe=1, OUT_memAddr={root,vpn[19:10],2'b00}[31:0]; stay until IN_memReady; then L1_WAIT.
//     If root[21:20]!=0 (address >32 bit): no read, go DONE with fault.
//   L1_WAIT/L0_WAIT: OUT_memRe=0; on IN_memValid evaluate PTE (V=b0,R=b1,W=b2,X=b3,U=b4,A=b6,D=b7):
//     fault if V=0, or (R=0 && W=1), or PTE[31:30]!=0 (PPN beyond 32-bit phys).
//     leaf (R|X) at L1: fault if PTE[19:10]!=0 (misaligned superpage); else isSuper=1.
//     leaf: fault if A=0, or (W=1 && D=0); else capture ppn/rwx/user.
//     non-leaf at L1: next L0_REQ, addr={PTE[29:10],vpn[9:0],2'b00}; non-leaf at L0: fault.
//   DONE: OUT_valid=1, OUT_busy=1 for exactly this cycle; fields valid; next IDLE (busy=0, new accept allowed).
//   Result fields hold their value until the next DONE.
//   Min latency, 0-wait memory (memReady=1, memValid next cycle), accept at T: superpage valid at T+3, 4K page at T+5.
//   rst mid-walk: abort immediately to reset state; no OUT_valid is produced for the aborted walk.
//   Only one memory read outstanding; OUT_memAddr stable while OUT_memRe=1 && !IN_memReady.
// TESTING
//   rootPPN=0x00080, vaddr 0x8040_1234, req0; read @0x0008_0804 returns 0x2000_004B -> valid at T+3, ppn=0x80000, isSuper=1, rwx=3'b101, user=0, fault=0.
//   Same vaddr; L1 returns 0x0002_0401, read @0x0008_1004 returns 0x2004_8CC7 -> ppn=0x80123, isSuper=0, rwx=3'b110, valid at T+5.
//   L1 PTE 0x0000_0000 (V=0) -> pageFault=1, ppn=0, single memory read, valid at T+3.
//   L1 leaf 0x2000_044B (PPN0=0x001) -> pageFault=1 (misaligned superpage).
//   req0 and req1 asserted same cycle -> rqID=0 served first; req1 held, accepted the cycle after DONE, rqID=1.
//   IN_memReady low 4 cycles in L1_REQ -> memRe/memAddr stable, valid delayed 4 cycles; rst asserted in L0_WAIT -> busy=0 next cycle, no valid strobe.

Source files
------------

// File: rtl/page_walker_if.sv
// Page-walk request/response bundle shared by the TLB miss paths, plus the walker's PTE read port.
interface page_walker_if #(
  parameter int NUM_RQ = 2,
  parameter int RQID_W = (NUM_RQ > 1) ? $clog2(NUM_RQ) : 1
);
  logic [NUM_RQ-1:0]    IN_reqValid;
  logic [NUM_RQ*32-1:0] IN_reqAddr;
  logic [NUM_RQ*22-1:0] IN_reqRoot;
  logic                 OUT_busy;
  logic [RQID_W-1:0]    OUT_rqID;
  logic                 OUT_valid;
  logic [19:0]          OUT_vpn;
  logic [19:0]          OUT_ppn;
  logic                 OUT_isSuper;
  logic [2:0]           OUT_rwx;
  logic                 OUT_user;
  logic                 OUT_pageFault;
  logic                 OUT_memRe;
  logic [31:0]          OUT_memAddr;
  logic                 IN_memReady;
  logic                 IN_memValid;
  logic [31:0]          IN_memData;

  modport slave (
    input  IN_reqValid, IN_reqAddr, IN_reqRoot, IN_memReady, IN_memValid, IN_memData,
    output OUT_busy, OUT_rqID, OUT_valid, OUT_vpn, OUT_ppn, OUT_isSuper, OUT_rwx,
           OUT_user, OUT_pageFault, OUT_memRe, OUT_memAddr
  );

  modport master (
    output IN_reqValid, IN_reqAddr, IN_reqRoot, IN_memReady, IN_memValid, IN_memData,
    input  OUT_busy, OUT_rqID, OUT_valid, OUT_vpn, OUT_ppn, OUT_isSuper, OUT_rwx,
           OUT_user, OUT_pageFault, OUT_memRe, OUT_memAddr
  );
endinterface

// File: rtl/page_walker.sv
// Sv32 page-table walker: arbitrates walk requests, reads up to two PTEs over a
// single-outstanding read port and returns a leaf translation or a page fault.
module page_walker #(
  parameter int NUM_RQ = 2,
  parameter int RQID_W = (NUM_RQ > 1) ? $clog2(NUM_RQ) : 1
) (
  input logic          clk,
  input logic          rst,
  page_walker_if.slave pw_io
);

  typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE} walkState_e;

  walkState_e        state_q, state_d;
  logic [19:0]       vpn_q, vpn_d;
  logic [21:0]       tablePpn_q, tablePpn_d;
  logic [RQID_W-1:0] rqId_q, rqId_d;
  logic [19:0]       resVpn_q, resVpn_d;
  logic [19:0]       resPpn_q, resPpn_d;
  logic              resSuper_q, resSuper_d;
  logic [2:0]        resRwx_q, resRwx_d;
  logic              resUser_q, resUser_d;
  logic              resFault_q, resFault_d;

  logic              reqFound;
  logic [RQID_W-1:0] reqSel;
  logic [19:0]       reqVpn;
  logic [21:0]       reqRoot;

  // Fixed priority: the lowest requestor index wins.
  always_comb begin
    reqFound = 1'b0;
    reqSel   = '0;
    reqVpn   = '0;
    reqRoot  = '0;
    for (int i = NUM_RQ - 1; i >= 0; i--) begin
      if (pw_io.IN_reqValid[i]) begin
        reqFound = 1'b1;
        reqSel   = RQID_W'(i);
        reqVpn   = pw_io.IN_reqAddr[i*32+12 +: 20];
        reqRoot  = pw_io.IN_reqRoot[i*22 +: 22];
      end
    end
  end

  logic [31:0] pte;
  logic        pteV, pteR, pteW, pteX, pteU, pteA, pteD;
  logic        pteLeaf, atL1, pteFault;
  logic        unusedPteBits;

  assign pte           = pw_io.IN_memData;
  assign pteV          = pte[0];
  assign pteR          = pte[1];
  assign pteW          = pte[2];
  assign pteX          = pte[3];
  assign pteU          = pte[4];
  assign pteA          = pte[6];
  assign pteD          = pte[7];
  assign unusedPteBits = ^{pte[9:8], pte[5]};
  assign atL1          = (state_q == L1_WAIT);
  assign pteLeaf       = pteR | pteX;

  // A pointer PTE seen at level 0 has nowhere left to go, so it faults too.
  assign pteFault = !pteV || (!pteR && pteW) || (pte[31:30] != 2'b00)
                 || (pteLeaf && atL1 && (pte[19:10] != 10'd0))
                 || (pteLeaf && (!pteA || (pteW && !pteD)))
                 || (!pteLeaf && !atL1);

  logic finish, finishFault, memRe;

  always_comb begin
    state_d     = state_q;
    vpn_d       = vpn_q;
    tablePpn_d  = tablePpn_q;
    rqId_d      = rqId_q;
    resVpn_d    = resVpn_q;
    resPpn_d    = resPpn_q;
    resSuper_d  = resSuper_q;
    resRwx_d    = resRwx_q;
    resUser_d   = resUser_q;
    resFault_d  = resFault_q;
    memRe       = 1'b0;
    finish      = 1'b0;
    finishFault = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (reqFound) begin
          state_d    = L1_REQ;
          vpn_d      = reqVpn;
          tablePpn_d = reqRoot;
          rqId_d     = reqSel;
        end
      end
      L1_REQ: begin
        if (tablePpn_q[21:20] != 2'b00) begin
          finish      = 1'b1;
          finishFault = 1'b1;
        end else begin
          memRe = 1'b1;
          if (pw_io.IN_memReady) state_d = L1_WAIT;
        end
      end
      L0_REQ: begin
        memRe = 1'b1;
        if (pw_io.IN_memReady) state_d = L0_WAIT;
      end
      L1_WAIT, L0_WAIT: begin
        if (pw_io.IN_memValid) begin
          if (pteFault) begin
            finish      = 1'b1;
            finishFault = 1'b1;
          end else if (pteLeaf) begin
            finish = 1'b1;
          end else begin
            state_d    = L0_REQ;
            tablePpn_d = {2'b00, pte[29:10]};
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Results are captured on the way into DONE and then held until the next walk ends.
    if (finish) begin
      state_d    = DONE;
      resVpn_d   = vpn_q;
      resFault_d = finishFault;
      resPpn_d   = finishFault ? 20'd0 : pte[29:10];
      resSuper_d = !finishFault && atL1;
      resRwx_d   = finishFault ? 3'b000 : {pteR, pteW, pteX};
      resUser_d  = !finishFault && pteU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vpn_q      <= '0;
      tablePpn_q <= '0;
      rqId_q     <= '0;
      resVpn_q   <= '0;
      resPpn_q   <= '0;
      resSuper_q <= 1'b0;
      resRwx_q   <= '0;
      resUser_q  <= 1'b0;
      resFault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vpn_q      <= vpn_d;
      tablePpn_q <= tablePpn_d;
      rqId_q     <= rqId_d;
      resVpn_q   <= resVpn_d;
      resPpn_q   <= resPpn_d;
      resSuper_q <= resSuper_d;
      resRwx_q   <= resRwx_d;
      resUser_q  <= resUser_d;
      resFault_q <= resFault_d;
    end
  end

  assign pw_io.OUT_busy      = (state_q != IDLE);
  assign pw_io.OUT_valid     = (state_q == DONE);
  assign pw_io.OUT_rqID      = rqId_q;
  assign pw_io.OUT_vpn       = resVpn_q;
  assign pw_io.OUT_ppn       = resPpn_q;
  assign pw_io.OUT_isSuper   = resSuper_q;
  assign pw_io.OUT_rwx       = resRwx_q;
  assign pw_io.OUT_user      = resUser_q;
  assign pw_io.OUT_pageFault = resFault_q;
  assign pw_io.OUT_memRe     = memRe;
  assign pw_io.OUT_memAddr   = {tablePpn_q[19:0],
                                (state_q == L0_REQ) ? vpn_q[9:0] : vpn_q[19:10], 2'b00};

endmodule
